bsg_fpu_class_gen: RTL
======================

# bsg_fpu_class_gen

Inverse of the FP classifier: takes a RISC-V `fclass`-style one-hot class mask and produces a half-precision operand of exactly that class. Accepted requests and results use ready/valid handshakes with a one-entry output register. A built-in sweep mode emits one operand of every class in order, with exponent and mantissa taken from an internal LFSR. The block drives FPU datapaths in testbenches and self-check logic, and its output is checkable by round-tripping through the classifier.

## Interface
- `e_p`, 5: exponent width.
- `m_p`, 10: mantissa width. The block is specified and verified only for `e_p=5`, `m_p=10`.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset, asynchronous, active-high.
- `v_i`  in  1  request valid.
- `ready_o`  out  1  request accepted when `v_i & ready_o`.
- `class_i`  in  16  class mask, fclass encoding:
  - 0 −inf, 1 −normal, 2 −subnormal, 3 −zero
  - 4 +zero, 5 +subnormal, 6 +normal, 7 +inf
  - 8 sNaN, 9 qNaN
  - bits 15:10 must be zero
- `exp_i`  in  `e_p`  requested exponent (used for normal classes only).
- `man_i`  in  `m_p`  requested mantissa/payload.
- `start_i`  in  1  sweep start pulse.
- `done_o`  out  1  one-cycle pulse when the last sweep item is loaded.
- `v_o`  out  1  result valid.
- `yumi_i`  in  1  result consumed. Legal only when `v_o` is high.
- `z_o`  out  16  generated operand.
- `class_o`  out  16  class mask that produced `z_o`.
- `err_o`  out  1  request mask was invalid.

## Operation
- **Encoding rules** (`s` = sign, `E` = `e_p` ones):
  - **inf:** `{s,E,0}`.
  - **zero:** `{s,0,0}`.
  - **normal:** exponent is `exp_i` clamped to [1, 30]: 0→1, 31→30. Mantissa is `man_i`.
  - **subnormal:** exponent 0. Mantissa is `man_i`, or 1 if `man_i == 0`.
  - **sNaN:** `{0,E,1'b0,p}`. `p = man_i[8:0]`, or 1 if that field is zero.
  - **qNaN:** `{0,E,1'b1,man_i[8:0]}`.
- **Invalid mask** (not exactly one bit set within [9:0], or any of bits [15:10] set):
  - `z_o = 16'h7E00`
  - `class_o = 16'h0200`
  - `err_o = 1`
- `err_o = 0` for every valid request and every sweep item.
- **FSM states:**
  - **IDLE:** directed requests are accepted.
    - `ready_o = (state==IDLE) & ~start_i & (~v_o | yumi_i)`.
    - `start_i` high in IDLE moves to SWEEP with `idx = 0`. `start_i` wins over a simultaneous `v_i`.
    - `start_i` is ignored outside IDLE.
  - **SWEEP:** `ready_o = 0`.
    - Each cycle with `(~v_o | yumi_i)`, the output register loads class `1<<idx`. Exponent and mantissa come from `lfsr[14:10]` and `lfsr[9:0]`, under the same rules as directed requests.
    - `idx` increments and the LFSR advances one step.
    - When `idx == 9` is loaded: `done_o` pulses, `idx` resets to 0, and the FSM returns to IDLE.
- **LFSR:**
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0.
  - Reset seed `16'hACE1`.
  - Advances only on sweep loads.
- **Output register:**
  - Loads on any accepted request or sweep load.
  - Holds stable while `v_o & ~yumi_i`.
  - `v_o` clears on `yumi_i` unless a new load occurs in the same cycle.

## Timing
- **Reset values:**
  - Outputs: `v_o = 0`, `z_o = 0`, `class_o = 0`, `err_o = 0`, `done_o = 0`.
  - Internal state: `state = IDLE`, `idx = 0`, `lfsr = 16'hACE1`.
  - `ready_o` is 1 after reset unless `start_i` is high.
- **Latency:** 1 cycle. A request accepted at edge n appears with `v_o = 1` after edge n.
- **Throughput:** one item per cycle when `yumi_i` is held high. Dequeue and load in the same cycle is permitted.
- **Backpressure:** while `v_o & ~yumi_i`:
  - no loads occur;
  - in SWEEP, `idx` and the LFSR freeze.
- **Sweep length:** with `yumi_i` tied high, items appear on 10 consecutive cycles and `done_o` coincides with the cycle that loads item 9.
- **Reset mid-sweep:** asserting `reset_i` returns all state to reset values immediately. The in-flight output is discarded and no `done_o` is emitted.

## Test plan
- **Directed requests:**
  - `class_i = 16'h0001` → `z_o = 16'hFC00`.
  - `class_i = 16'h0040`, `exp_i = 0`, `man_i = 10'h155` → `z_o = 16'h0555`.
  - `class_i = 16'h0020`, `man_i = 0` → `z_o = 16'h0001`.
- **NaN requests:**
  - `class_i = 16'h0100`, `man_i = 0` → `z_o = 16'h7C01`.
  - `class_i = 16'h0200`, `man_i = 0` → `z_o = 16'h7E00`.
- **Invalid mask:** `class_i = 16'h0003` or `16'h0400` → `z_o = 16'h7E00`, `class_o = 16'h0200`, `err_o = 1`.
- **Sweep:** `start_i` pulse with `yumi_i = 1`:
  - `class_o` takes values `16'h0001` through `16'h0200` on 10 consecutive cycles;
  - the first `z_o` is `16'hFC00`;
  - `done_o` pulses once;
  - every `z_o`, fed to the classifier, reproduces `class_o`.
- **Backpressure:** `yumi_i = 0` for 3 cycles mid-sweep → `z_o` and `class_o` stay stable, `ready_o = 0`, and the sequence resumes with no skipped or duplicated class.
- **Simultaneous events:**
  - `start_i` and `v_i` together in IDLE → the request is not accepted and the sweep starts.
  - `reset_i` asserted during sweep item 4 → `v_o = 0` immediately. The next sweep restarts at `16'hFC00` with LFSR `16'hACE1`.

Source files
------------

// File: rtl/bsg_fpu_class_gen.sv
// bsg_fpu_class_gen: builds a half-precision operand of a requested fclass
// category. Directed requests and an LFSR-driven sweep over all ten classes
// share one encoder and a single-entry ready/valid output register.
module bsg_fpu_class_gen #(
    parameter int e_p = 5,
    parameter int m_p = 10
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             v_i,
    output logic             ready_o,
    input  logic [15:0]      class_i,
    input  logic [e_p-1:0]   exp_i,
    input  logic [m_p-1:0]   man_i,
    input  logic             start_i,
    output logic             done_o,
    output logic             v_o,
    input  logic             yumi_i,
    output logic [e_p+m_p:0] z_o,
    output logic [15:0]      class_o,
    output logic             err_o
);

    localparam int w_lp = e_p + m_p + 1;

    localparam logic [e_p-1:0] exp_ones_lp = {e_p{1'b1}};
    localparam logic [e_p-1:0] exp_min_lp  = {{(e_p-1){1'b0}}, 1'b1};
    localparam logic [e_p-1:0] exp_max_lp  = {{(e_p-1){1'b1}}, 1'b0};
    localparam logic [m_p-1:0] man_one_lp  = {{(m_p-1){1'b0}}, 1'b1};
    localparam logic [m_p-2:0] pay_one_lp  = {{(m_p-2){1'b0}}, 1'b1};
    localparam logic [w_lp-1:0] qnan_lp    = {1'b0, exp_ones_lp, 1'b1, {(m_p-1){1'b0}}};

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    state_e      state_r, state_n;
    logic [3:0]  idx_r, idx_n;
    logic [15:0] lfsr_r, lfsr_n;

    logic slot_free;
    logic sweep_load;
    logic accept;
    logic load;

    logic [15:0]     sel_class;
    logic [e_p-1:0]  sel_exp;
    logic [m_p-1:0]  sel_man;
    logic [e_p-1:0]  exp_clamped;
    logic [m_p-1:0]  man_sub;
    logic [m_p-2:0]  snan_pay;
    logic            mask_ok;
    logic            sign;
    logic [w_lp-1:0] enc_z;
    logic [15:0]     enc_class;
    logic            enc_err;

    assign slot_free = ~v_o | yumi_i;
    assign accept    = v_i & ready_o;
    assign load      = accept | sweep_load;

    // State, sweep index and LFSR registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE;
            idx_r   <= '0;
            lfsr_r  <= 16'hACE1;
        end else begin
            state_r <= state_n;
            idx_r   <= idx_n;
            lfsr_r  <= lfsr_n;
        end
    end

    // Next-state logic: IDLE takes requests or a sweep start, SWEEP emits one class per free slot
    always_comb begin
        state_n    = state_r;
        idx_n      = idx_r;
        lfsr_n     = lfsr_r;
        ready_o    = 1'b0;
        done_o     = 1'b0;
        sweep_load = 1'b0;
        case (state_r)
            IDLE: begin
                ready_o = ~start_i & slot_free;
                if (start_i) begin
                    state_n = SWEEP;
                    idx_n   = '0;
                end
            end
            SWEEP: begin
                if (slot_free) begin
                    sweep_load = 1'b1;
                    lfsr_n     = {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
                    if (idx_r == 4'd9) begin
                        done_o  = 1'b1;
                        idx_n   = '0;
                        state_n = IDLE;
                    end else begin
                        idx_n = idx_r + 4'd1;
                    end
                end
            end
        endcase
    end

    // Encoder: turns a one-hot class plus exponent/mantissa hints into an operand of that class
    always_comb begin
        sel_class = (state_r == SWEEP) ? (16'd1 << idx_r)     : class_i;
        sel_exp   = (state_r == SWEEP) ? lfsr_r[m_p +: e_p]  : exp_i;
        sel_man   = (state_r == SWEEP) ? lfsr_r[m_p-1:0]     : man_i;

        mask_ok = (sel_class[15:10] == '0) && (sel_class[9:0] != '0)
                  && ((sel_class[9:0] & (sel_class[9:0] - 10'd1)) == '0);
        sign    = |sel_class[3:0];

        if (sel_exp == '0)               exp_clamped = exp_min_lp;
        else if (sel_exp == exp_ones_lp) exp_clamped = exp_max_lp;
        else                             exp_clamped = sel_exp;

        man_sub  = (sel_man == '0) ? man_one_lp : sel_man;
        snan_pay = (sel_man[m_p-2:0] == '0) ? pay_one_lp : sel_man[m_p-2:0];

        enc_z     = qnan_lp;
        enc_class = 16'h0200;
        enc_err   = 1'b1;
        if (mask_ok) begin
            enc_class = sel_class;
            enc_err   = 1'b0;
            if (sel_class[0] | sel_class[7])
                enc_z = {sign, exp_ones_lp, {m_p{1'b0}}};
            else if (sel_class[3] | sel_class[4])
                enc_z = {sign, {e_p{1'b0}}, {m_p{1'b0}}};
            else if (sel_class[1] | sel_class[6])
                enc_z = {sign, exp_clamped, sel_man};
            else if (sel_class[2] | sel_class[5])
                enc_z = {sign, {e_p{1'b0}}, man_sub};
            else if (sel_class[8])
                enc_z = {1'b0, exp_ones_lp, 1'b0, snan_pay};
            else
                enc_z = {1'b0, exp_ones_lp, 1'b1, sel_man[m_p-2:0]};
        end
    end

    // Single-entry output register; a load in the same cycle as yumi keeps v_o high
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            v_o     <= 1'b0;
            z_o     <= '0;
            class_o <= '0;
            err_o   <= 1'b0;
        end else if (load) begin
            v_o     <= 1'b1;
            z_o     <= enc_z;
            class_o <= enc_class;
            err_o   <= enc_err;
        end else if (yumi_i) begin
            v_o <= 1'b0;
        end
    end

endmodule
